// File: rtl/ysyx_23060077_bpu.sv
// Branch unit: resolves conditional branches in EX and keeps a PC-indexed BHT of
// saturating counters that gives IF a direction prediction one cycle after it asks.
module ysyx_23060077_bpu #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CTR_W     = 2,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pred_req,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_resp_valid,
    output logic             pred_resp_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    output logic             branch_taken,
    output logic             mispredict,
    output logic             init_done,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam int unsigned InitInt = (1 << (CTR_W - 1)) - 1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(InitInt);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BHT_DEPTH - 1);

    typedef enum logic {StInit, StRun} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic [CTR_W-1:0] bht_q [BHT_DEPTH];

    logic [IDX_W-1:0] pred_idx, ex_idx;
    logic             cond, legal, active;
    logic             bht_we;
    logic [IDX_W-1:0] bht_widx;
    logic [CTR_W-1:0] bht_wdata, ctr_old;

    logic             pred_valid_q, pred_taken_q;
    logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

    logic unused_pc_bits;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign ex_idx   = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[1:0], pred_pc[XLEN-1:IDX_W+2],
                              ex_pc[1:0], ex_pc[XLEN-1:IDX_W+2]};

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (ex_funct3)
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond = (ex_rs1 <  ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: legal = 1'b0;
        endcase
    end

    assign active       = ex_valid & ex_branch & legal;
    assign branch_taken = active & cond;
    assign mispredict   = active & (cond != ex_pred_taken);

    assign ctr_old = bht_q[ex_idx];

    // The sweep owns the write port during INIT, so training is silently dropped there.
    always_comb begin
        state_d     = state_q;
        sweep_idx_d = sweep_idx_q;
        bht_we      = 1'b0;
        bht_widx    = ex_idx;
        bht_wdata   = ctr_old;
        case (state_q)
            StInit: begin
                bht_we      = 1'b1;
                bht_widx    = sweep_idx_q;
                bht_wdata   = CTR_INIT;
                sweep_idx_d = sweep_idx_q + 1'b1;
                if (sweep_idx_q == IDX_LAST) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (active) begin
                    bht_we = 1'b1;
                    if (cond) begin
                        bht_wdata = (ctr_old == CTR_MAX) ? ctr_old : ctr_old + 1'b1;
                    end else begin
                        bht_wdata = (ctr_old == '0) ? ctr_old : ctr_old - 1'b1;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StInit;
            sweep_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
        end
    end

    // Table has no reset; only entries written by the sweep are ever observed.
    always_ff @(posedge clock) begin
        if (bht_we && !reset) begin
            bht_q[bht_widx] <= bht_wdata;
        end
    end

    // Non-blocking read of bht_q gives read-before-write on a same-index collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            pred_valid_q <= pred_req;
            if (pred_req) begin
                pred_taken_q <= (state_q == StRun) & bht_q[pred_idx][CTR_W-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (active) begin
                br_cnt_q <= br_cnt_q + 1'b1;
            end
            if (mispredict) begin
                mis_cnt_q <= mis_cnt_q + 1'b1;
            end
        end
    end

    assign pred_resp_valid = pred_valid_q;
    assign pred_resp_taken = pred_taken_q;
    assign init_done       = (state_q == StRun);
    assign br_cnt          = br_cnt_q;
    assign mis_cnt         = mis_cnt_q;

endmodule

// File: tb/tb_ysyx_23060077_bpu.sv
// Self-checking bench for ysyx_23060077_bpu: scoreboarded predictions, a small BHT
// model, and directed branch-resolve tables. Statistics counters are 4 bits wide here.
module tb_ysyx_23060077_bpu;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int CNTW  = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            pred_req;
    logic [XLEN-1:0] pred_pc;
    logic            pred_resp_valid, pred_resp_taken;
    logic            ex_valid, ex_branch, ex_pred_taken;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_rs1, ex_rs2, ex_pc;
    logic            branch_taken, mispredict, init_done;
    logic [CNTW-1:0] br_cnt, mis_cnt;

    int total = 0;
    int bad   = 0;
    int model_bht [DEPTH];
    bit run_phase = 1'b0;
    int exp_br = 0;
    int exp_mis = 0;
    bit exp_q [$];
    bit exp_t;

    always #5 clock = ~clock;

    ysyx_23060077_bpu #(
        .XLEN(XLEN), .BHT_DEPTH(DEPTH), .CTR_W(2), .CNT_W(CNTW)
    ) dut (
        .clock(clock), .reset(reset),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_resp_valid(pred_resp_valid), .pred_resp_taken(pred_resp_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .branch_taken(branch_taken), .mispredict(mispredict), .init_done(init_done),
        .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        pred_req = 1'b0; pred_pc = '0;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_funct3 = 3'b000;
        ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_pred_taken = 1'b0;
    endtask

    task automatic drive_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic pt);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_funct3 = f3;
        ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_pred_taken = pt;
    endtask

    // Model bookkeeping for a branch that has just been clocked in.
    task automatic commit_branch(input bit legal, input bit taken, input bit pt,
                                 input logic [31:0] pc);
        int idx;
        idx = int'(pc[7:2]);
        if (legal) begin
            exp_br = (exp_br + 1) % 16;
            if (taken != pt) exp_mis = (exp_mis + 1) % 16;
            if (run_phase) begin
                if (taken && model_bht[idx] < 3) model_bht[idx]++;
                if (!taken && model_bht[idx] > 0) model_bht[idx]--;
            end
        end
    endtask

    task automatic model_reset;
        for (int i = 0; i < DEPTH; i++) model_bht[i] = 1;
        exp_br = 0; exp_mis = 0; run_phase = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        tick(); tick();
        total += 5;
        if (pred_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", pred_resp_valid); end
        if (pred_resp_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b want=0", pred_resp_taken); end
        if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%b want=0", init_done); end
        if (br_cnt !== 4'd0) begin bad++; $display("FAIL reset_br_cnt got=%0d want=0", br_cnt); end
        if (mis_cnt !== 4'd0) begin bad++; $display("FAIL reset_mis_cnt got=%0d want=0", mis_cnt); end
    endtask

    task automatic test_init_sweep;
        reset = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            total++;
            if (init_done !== 1'b0) begin bad++; $display("FAIL sweep1_c%0d init_done got=%b want=0", c, init_done); end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 1; c <= DEPTH; c++) begin
            if (c == 5) begin
                pred_req = 1'b1; pred_pc = 32'h10;
                exp_q.push_back(1'b0);
            end
            if (c == 9) drive_branch(3'b000, 32'd9, 32'd9, 32'h20, 1'b1);
            tick();
            if (c == 5) begin
                pred_req = 1'b0;
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL init_pred scoreboard empty got=none want=entry"); end
                else begin
                    exp_t = exp_q.pop_front();
                    if (pred_resp_valid !== 1'b1 || pred_resp_taken !== exp_t) begin
                        bad++;
                        $display("FAIL init_pred got=v%b t%b want=v1 t%b", pred_resp_valid, pred_resp_taken, exp_t);
                    end
                end
            end
            if (c == 9) begin
                commit_branch(1'b1, 1'b1, 1'b1, 32'h20);
                idle_inputs();
            end
            total++;
            if (init_done !== (c == DEPTH)) begin
                bad++; $display("FAIL sweep2_c%0d init_done got=%b want=%b", c, init_done, (c == DEPTH));
            end
        end
        run_phase = 1'b1;
        total++;
        if (br_cnt !== CNTW'(exp_br)) begin bad++; $display("FAIL init_br_cnt got=%0d want=%0d", br_cnt, exp_br); end
    endtask

    task automatic test_compare;
        logic [2:0]  f3 [7]  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b000, 3'b001, 3'b010};
        logic [31:0] a  [7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd5, 32'd5, 32'd5};
        logic [31:0] b  [7]  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'd5};
        bit          tk [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bit          lg [7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit          pt [7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bit          mp [7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive_branch(f3[i], a[i], b[i], 32'h40 + 32'(4 * i), pt[i]);
            #1;
            total += 2;
            if (branch_taken !== tk[i]) begin bad++; $display("FAIL cmp%0d_taken got=%b want=%b", i, branch_taken, tk[i]); end
            if (mispredict !== mp[i]) begin bad++; $display("FAIL cmp%0d_mispredict got=%b want=%b", i, mispredict, mp[i]); end
            tick();
            commit_branch(lg[i], tk[i], pt[i], 32'h40 + 32'(4 * i));
            idle_inputs();
            total += 2;
            if (br_cnt !== CNTW'(exp_br)) begin bad++; $display("FAIL cmp%0d_br_cnt got=%0d want=%0d", i, br_cnt, exp_br); end
            if (mis_cnt !== CNTW'(exp_mis)) begin bad++; $display("FAIL cmp%0d_mis_cnt got=%0d want=%0d", i, mis_cnt, exp_mis); end
        end
    endtask

    task automatic test_train;
        bit want [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            if (k < 3) drive_branch(3'b000, 32'd3, 32'd3, 32'h8000_0010, 1'b0);
            else       drive_branch(3'b001, 32'd3, 32'd3, 32'h8000_0010, 1'b0);
            tick();
            commit_branch(1'b1, k < 3, 1'b0, 32'h8000_0010);
            idle_inputs();
            pred_req = 1'b1; pred_pc = 32'h8000_0010;
            exp_q.push_back(want[k]);
            tick();
            pred_req = 1'b0;
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL train%0d scoreboard empty got=none want=entry", k); end
            else begin
                exp_t = exp_q.pop_front();
                if (pred_resp_valid !== 1'b1 || pred_resp_taken !== exp_t) begin
                    bad++; $display("FAIL train%0d_pred got=v%b t%b want=v1 t%b", k, pred_resp_valid, pred_resp_taken, exp_t);
                end
            end
        end
        // Entry trained only while sweeping must still read weakly not-taken.
        pred_req = 1'b1; pred_pc = 32'h20;
        exp_q.push_back(1'b0);
        tick();
        pred_req = 1'b0;
        total++;
        exp_t = exp_q.pop_front();
        if (pred_resp_taken !== exp_t) begin bad++; $display("FAIL init_train_dropped got=%b want=%b", pred_resp_taken, exp_t); end
        tick();
        total++;
        if (pred_resp_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", pred_resp_valid); end
    endtask

    task automatic test_mispredict;
        drive_branch(3'b000, 32'd7, 32'd7, 32'h84, 1'b0);
        #1;
        total++;
        if (mispredict !== 1'b1) begin bad++; $display("FAIL mp_beq got=%b want=1", mispredict); end
        tick();
        commit_branch(1'b1, 1'b1, 1'b0, 32'h84);
        total++;
        if (mis_cnt !== CNTW'(exp_mis)) begin bad++; $display("FAIL mp_count got=%0d want=%0d", mis_cnt, exp_mis); end
        ex_branch = 1'b0;
        #1;
        total += 2;
        if (mispredict !== 1'b0) begin bad++; $display("FAIL mp_nobranch got=%b want=0", mispredict); end
        if (branch_taken !== 1'b0) begin bad++; $display("FAIL mp_nobranch_taken got=%b want=0", branch_taken); end
        tick();
        idle_inputs();
        total += 2;
        if (mis_cnt !== CNTW'(exp_mis)) begin bad++; $display("FAIL mp_nocount got=%0d want=%0d", mis_cnt, exp_mis); end
        if (br_cnt !== CNTW'(exp_br)) begin bad++; $display("FAIL mp_nobr got=%0d want=%0d", br_cnt, exp_br); end
    endtask

    task automatic test_collision;
        bit want [2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            pred_req = 1'b1; pred_pc = 32'h30;
            exp_q.push_back(want[k]);
            if (k == 0) drive_branch(3'b000, 32'd1, 32'd1, 32'h30, 1'b0);
            tick();
            if (k == 0) commit_branch(1'b1, 1'b1, 1'b0, 32'h30);
            idle_inputs();
            total++;
            exp_t = exp_q.pop_front();
            if (pred_resp_valid !== 1'b1 || pred_resp_taken !== exp_t) begin
                bad++; $display("FAIL collide%0d got=v%b t%b want=v1 t%b", k, pred_resp_valid, pred_resp_taken, exp_t);
            end
        end
    endtask

    task automatic test_back_to_back;
        int guard;
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_branch(3'b101, 32'd2, 32'd1, 32'h4, 1'b1);
            tick();
            commit_branch(1'b1, 1'b1, 1'b1, 32'h4);
            total++;
            if (br_cnt !== CNTW'(exp_br)) begin bad++; $display("FAIL b2b%0d_br_cnt got=%0d want=%0d", i, br_cnt, exp_br); end
        end
        idle_inputs();
        total++;
        if (br_cnt !== 4'd0) begin bad++; $display("FAIL wrap got=%0d want=0", br_cnt); end
        guard = 0;
        while (init_done !== 1'b1 && guard < 100) begin tick(); guard++; end
        total++;
        if (init_done !== 1'b1) begin bad++; $display("FAIL wrap_sweep_timeout got=%b want=1", init_done); end
        run_phase = 1'b1;
        // pcs 0x0 and 0x100 alias to entry 0.
        for (int i = 0; i < 2; i++) begin
            drive_branch(3'b000, 32'd0, 32'd0, 32'h0, 1'b0);
            tick();
            commit_branch(1'b1, 1'b1, 1'b0, 32'h0);
        end
        idle_inputs();
        pred_req = 1'b1; pred_pc = 32'h100;
        exp_q.push_back(1'b1);
        tick();
        pred_req = 1'b0;
        total++;
        exp_t = exp_q.pop_front();
        if (pred_resp_taken !== exp_t || model_bht[0] != 3) begin
            bad++; $display("FAIL alias_up got=%b want=%b", pred_resp_taken, exp_t);
        end
        for (int i = 0; i < 2; i++) begin
            drive_branch(3'b001, 32'd0, 32'd0, 32'h100, 1'b0);
            tick();
            commit_branch(1'b1, 1'b0, 1'b0, 32'h100);
        end
        idle_inputs();
        pred_req = 1'b1; pred_pc = 32'h0;
        exp_q.push_back(1'b0);
        tick();
        pred_req = 1'b0;
        total += 3;
        exp_t = exp_q.pop_front();
        if (pred_resp_taken !== exp_t) begin bad++; $display("FAIL alias_down got=%b want=%b", pred_resp_taken, exp_t); end
        if (br_cnt !== CNTW'(exp_br)) begin bad++; $display("FAIL final_br_cnt got=%0d want=%0d", br_cnt, exp_br); end
        if (mis_cnt !== CNTW'(exp_mis)) begin bad++; $display("FAIL final_mis_cnt got=%0d want=%0d", mis_cnt, exp_mis); end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_compare();
        test_train();
        test_mispredict();
        test_collision();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
